// File: rtl/fbuf_wr_ctrl_pkg.sv
// rtl/fbuf_wr_ctrl_pkg.sv - state encoding and parameter defaults shared by the frame buffer write controller
package fbuf_wr_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FBUF_DEPTH = 230400;
    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_BURST_LEN  = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_BURST     = 2'd2
    } wr_state_t;

endpackage

// File: rtl/fbuf_wr_ctrl_if.sv
// rtl/fbuf_wr_ctrl_if.sv - camera FIFO read side and frame buffer write side of the write controller
interface fbuf_wr_ctrl_if
    import fbuf_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  i_almostempty;
    logic                  o_rd;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  o_wr;
    logic [ADDR_WIDTH-1:0] o_waddr;
    logic [DATA_WIDTH-1:0] o_wdata;
    logic                  o_pix_valid;
    logic                  o_frame_done;

    modport master (
        input  i_almostempty,
        input  i_rdata,
        output o_rd,
        output o_wr,
        output o_waddr,
        output o_wdata,
        output o_pix_valid,
        output o_frame_done
    );

    modport slave (
        output i_almostempty,
        output i_rdata,
        input  o_rd,
        input  o_wr,
        input  o_waddr,
        input  o_wdata,
        input  o_pix_valid,
        input  o_frame_done
    );

endinterface

// File: rtl/fbuf_addr_gen.sv
// rtl/fbuf_addr_gen.sv - linear frame buffer write address with wrap at frame end and frame_done pulse
module fbuf_addr_gen
    import fbuf_wr_ctrl_pkg::*;
#(
    parameter int FBUF_DEPTH = DEF_FBUF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic                  i_clr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_frame_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FBUF_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_at_end;

    assign w_at_end = (r_addr == LAST_ADDR);

    // r_addr is the address of the write presented this cycle; a clear still lets that write land
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if (i_clr || (i_wr && w_at_end)) begin
            r_addr <= '0;
        end else if (i_wr) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr       = r_addr;
    assign o_frame_done = i_wr && w_at_end;

endmodule

// File: rtl/fbuf_wr_ctrl.sv
// rtl/fbuf_wr_ctrl.sv - burst scheduler from camera FIFO to frame buffer write port
// Optional statistics counters are built when FBUF_WR_STATS_EN is defined.
module fbuf_wr_ctrl
    import fbuf_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FBUF_DEPTH = DEF_FBUF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
    input  logic           i_sof,
    fbuf_wr_ctrl_if.master io_bus,
    output logic           o_busy,
    output logic [15:0]    o_frame_cnt,
    output logic [7:0]     o_resync_cnt
);

    localparam int                    CNT_W      = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]      BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] PIX_LAST   = ADDR_WIDTH'(FBUF_DEPTH - 1);

    wr_state_t             r_state;
    wr_state_t             w_next;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic                  r_wr;
    logic                  r_clr_pend;
    logic                  w_rd;
    logic                  w_busy;
    logic                  w_start;
    logic                  w_resync;
    logic                  w_last_pix;
    logic                  w_burst_end;
    logic                  w_addr_clr;
    logic                  w_frame_done;
    logic [ADDR_WIDTH-1:0] w_waddr;

    assign w_start     = i_sof && !i_flush && (r_state == ST_IDLE);
    assign w_resync    = i_sof && !i_flush && (r_state != ST_IDLE);
    assign w_last_pix  = (r_rd_cnt == PIX_LAST);
    assign w_burst_end = (r_burst_cnt == BURST_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sof) w_next = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (!i_sof && !io_bus.i_almostempty) w_next = ST_BURST;
                end
                ST_BURST: begin
                    // a burst is cut short at the last pixel so it never spans two frames
                    if (i_sof)            w_next = ST_WAIT_DATA;
                    else if (w_last_pix)  w_next = ST_IDLE;
                    else if (w_burst_end) w_next = ST_WAIT_DATA;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd   = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            ST_WAIT_DATA: w_busy = 1'b1;
            ST_BURST: begin
                w_rd   = 1'b1;
                w_busy = 1'b1;
            end
            default: begin
                w_rd   = 1'b0;
                w_busy = 1'b0;
            end
        endcase
    end

    // r_clr_pend holds a resync address clear back one cycle so the in-flight read lands at the old address
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_burst_cnt <= '0;
            r_rd_cnt    <= '0;
            r_wr        <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_wr       <= w_rd && !i_flush;
            r_clr_pend <= w_resync;
            if ((r_state == ST_BURST) && (w_next == ST_BURST)) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else begin
                r_burst_cnt <= '0;
            end
            if (i_flush || i_sof) begin
                r_rd_cnt <= '0;
            end else if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign w_addr_clr = i_flush || w_start || r_clr_pend;

    fbuf_addr_gen #(
        .FBUF_DEPTH (FBUF_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr         (r_wr),
        .i_clr        (w_addr_clr),
        .o_addr       (w_waddr),
        .o_frame_done (w_frame_done)
    );

    // FIFO data arrives the cycle after o_rd, which is exactly when r_wr is high
    assign io_bus.o_rd         = w_rd;
    assign io_bus.o_wr         = r_wr;
    assign io_bus.o_pix_valid  = r_wr;
    assign io_bus.o_wdata      = r_wr ? io_bus.i_rdata : '0;
    assign io_bus.o_waddr      = w_waddr;
    assign io_bus.o_frame_done = w_frame_done;
    assign o_busy              = w_busy;

`ifdef FBUF_WR_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_resync_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_cnt  <= '0;
            r_resync_cnt <= '0;
        end else begin
            if (w_frame_done && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_resync && (r_resync_cnt != 8'hFF)) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end
        end
    end

    assign o_frame_cnt  = r_frame_cnt;
    assign o_resync_cnt = r_resync_cnt;
`else
    assign o_frame_cnt  = '0;
    assign o_resync_cnt = '0;
`endif

endmodule

// File: tb/tb_fbuf_wr_ctrl.sv
// tb/tb_fbuf_wr_ctrl.sv - randomized self-checking bench for fbuf_wr_ctrl against a frame-level reference model
module tb_fbuf_wr_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int BL    = 16;
`ifdef FBUF_WR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        sof = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  resync_cnt;
    logic [DW-1:0] fifo_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;
    int exp_frames = 0;
    int cyc = 0;
    int stray_done = 0;
    int rd_cyc[$];
    int wr_cyc[$];
    int wr_addr[$];
    int wr_data[$];
    int wr_done[$];
    int pop_q[$];

    fbuf_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fbuf_wr_ctrl #(.DATA_WIDTH(DW), .FBUF_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_sof        (sof),
        .io_bus       (bus),
        .o_busy       (busy),
        .o_frame_cnt  (frame_cnt),
        .o_resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    assign bus.i_rdata = fifo_rdata;

    // FIFO model: each read returns a fresh random word one cycle later
    always @(posedge clk) begin : fifo_model
        int unsigned rv;
        if (bus.o_rd) begin
            rv = $urandom;
            fifo_rdata <= rv[DW-1:0];
            pop_q.push_back(int'(rv[DW-1:0]));
        end
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus.o_rd) rd_cyc.push_back(cyc);
        if (bus.o_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(bus.o_waddr));
            wr_data.push_back(int'(bus.o_wdata));
            wr_done.push_back(int'(bus.o_frame_done));
        end else if (bus.o_frame_done) begin
            stray_done++;
        end
    end

    task automatic clear_logs();
        rd_cyc.delete(); wr_cyc.delete(); wr_addr.delete();
        wr_data.delete(); wr_done.delete(); pop_q.delete();
        stray_done = 0;
    endtask

    // Writes since the last clear must be address i, i-th popped word, done only at DEPTH-1, one cycle after read i
    function automatic int frame_bad();
        int bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i) bad++;
            if (i >= pop_q.size() || wr_data[i] != pop_q[i]) bad++;
            if (wr_done[i] != ((i == DEPTH - 1) ? 1 : 0)) bad++;
            if (i >= rd_cyc.size() || wr_cyc[i] != rd_cyc[i] + 1) bad++;
        end
        return bad;
    endfunction

    function automatic int burst_bad();
        int exp_len[$];
        int got_len[$];
        int left = DEPTH;
        int run = 0;
        int bad = 0;
        while (left > 0) begin
            exp_len.push_back((left < BL) ? left : BL);
            left -= (left < BL) ? left : BL;
        end
        for (int i = 0; i < rd_cyc.size(); i++) begin
            if (i > 0 && rd_cyc[i] != rd_cyc[i-1] + 1) begin
                got_len.push_back(run);
                run = 0;
            end
            run++;
        end
        if (rd_cyc.size() > 0) got_len.push_back(run);
        if (got_len.size() != exp_len.size()) return 1000 + got_len.size();
        for (int i = 0; i < exp_len.size(); i++) if (got_len[i] != exp_len[i]) bad++;
        return bad;
    endfunction

    task automatic pulse_sof();
        @(negedge clk); sof = 1'b1;
        @(negedge clk); sof = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bus.i_almostempty = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (bus.o_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b exp=0", bus.o_rd); end
        n_checks++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", bus.o_wr); end
        n_checks++; if (bus.o_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", bus.o_waddr); end
        n_checks++; if (bus.o_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.o_wdata); end
        n_checks++; if (bus.o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.o_frame_done); end
        n_checks++; if (frame_cnt !== 16'd0 || resync_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", frame_cnt, resync_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_idle_no_sof();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++; if (bus.o_rd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_cycle%0d rd/busy got=%b/%b exp=0/0", i, bus.o_rd, busy); end
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        clear_logs();
        bus.i_almostempty = 1'b0;
        pulse_sof();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_frame_timeout got=busy exp=idle"); end
        n_checks++; if (wr_addr.size() !== DEPTH) begin n_fail++; $display("FAIL full_frame_writes got=%0d exp=%0d", wr_addr.size(), DEPTH); end
        n_checks++; if (frame_bad() !== 0) begin n_fail++; $display("FAIL full_frame_content got=%0d bad exp=0", frame_bad()); end
        n_checks++; if (burst_bad() !== 0) begin n_fail++; $display("FAIL full_frame_bursts got=%0d bad exp=0", burst_bad()); end
        n_checks++; if (stray_done !== 0) begin n_fail++; $display("FAIL full_frame_stray_done got=%0d exp=0", stray_done); end
        exp_frames++;
    endtask

    task automatic test_almost_empty();
        bit ok;
        clear_logs();
        bus.i_almostempty = 1'b1;
        pulse_sof();
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (bus.o_rd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ae_hold%0d rd/busy got=%b/%b exp=0/1", i, bus.o_rd, busy); end
            @(negedge clk);
        end
        bus.i_almostempty = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_rd !== 1'b1 || rd_cyc.size() !== 1) begin n_fail++; $display("FAIL ae_first_rd got=%b/%0d exp=1/1", bus.o_rd, rd_cyc.size()); end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
            bus.i_almostempty = ($urandom_range(0, 2) == 0);
        end
        bus.i_almostempty = 1'b0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ae_timeout got=busy exp=idle"); end
        n_checks++; if (wr_addr.size() !== DEPTH) begin n_fail++; $display("FAIL ae_writes got=%0d exp=%0d", wr_addr.size(), DEPTH); end
        n_checks++; if (frame_bad() !== 0) begin n_fail++; $display("FAIL ae_content got=%0d bad exp=0", frame_bad()); end
        n_checks++; if (burst_bad() !== 0) begin n_fail++; $display("FAIL ae_bursts got=%0d bad exp=0", burst_bad()); end
        exp_frames++;
    endtask

    task automatic test_resync();
        bit ok;
        bit found = 1'b0;
        clear_logs();
        pulse_sof();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_wr && bus.o_waddr == AW'(10)) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL resync_find_w10 got=none exp=write10"); end
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        n_checks++; if (bus.o_rd !== 1'b0) begin n_fail++; $display("FAIL resync_rd_drop got=%b exp=0", bus.o_rd); end
        n_checks++; if (bus.o_wr !== 1'b1 || bus.o_waddr !== AW'(11)) begin n_fail++; $display("FAIL resync_inflight got=%b@%0d exp=1@11", bus.o_wr, bus.o_waddr); end
        n_checks++; if (frame_bad() !== 0 || wr_addr.size() !== 12) begin n_fail++; $display("FAIL resync_partial got=%0d bad/%0d writes exp=0/12", frame_bad(), wr_addr.size()); end
        clear_logs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL resync_timeout got=busy exp=idle"); end
        n_checks++; if (wr_addr.size() !== DEPTH || frame_bad() !== 0) begin n_fail++; $display("FAIL resync_refill got=%0d writes/%0d bad exp=%0d/0", wr_addr.size(), frame_bad(), DEPTH); end
        n_checks++; if (burst_bad() !== 0) begin n_fail++; $display("FAIL resync_bursts got=%0d bad exp=0", burst_bad()); end
        n_checks++; if (resync_cnt !== (STATS ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL resync_cnt got=%0d exp=%0d", resync_cnt, STATS ? 1 : 0); end
        exp_frames++;
    endtask

    task automatic test_flush();
        bit ok;
        bit found = 1'b0;
        clear_logs();
        pulse_sof();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_wr && bus.o_waddr == AW'(5)) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL flush_find_w5 got=none exp=write5"); end
        flush = 1'b1;
        sof = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sof = 1'b0;
        n_checks++; if (bus.o_rd !== 1'b0 || bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL flush_stop rd/wr got=%b/%b exp=0/0", bus.o_rd, bus.o_wr); end
        n_checks++; if (busy !== 1'b0 || bus.o_waddr !== '0) begin n_fail++; $display("FAIL flush_idle busy/addr got=%b/%0d exp=0/0", busy, bus.o_waddr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_sof_ignored%0d got=%b exp=0", i, busy); end
        end
        n_checks++; if (resync_cnt !== (STATS ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL flush_resync_cnt got=%0d exp=%0d", resync_cnt, STATS ? 1 : 0); end
        clear_logs();
        pulse_sof();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_restart_timeout got=busy exp=idle"); end
        n_checks++; if (wr_addr.size() !== DEPTH || frame_bad() !== 0) begin n_fail++; $display("FAIL flush_restart got=%0d writes/%0d bad exp=%0d/0", wr_addr.size(), frame_bad(), DEPTH); end
        exp_frames++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit found = 1'b0;
        clear_logs();
        pulse_sof();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.o_frame_done) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1 || bus.o_waddr !== AW'(DEPTH - 1)) begin n_fail++; $display("FAIL b2b_done got=%b@%0d exp=1@%0d", found, bus.o_waddr, DEPTH - 1); end
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_sof_accept got=%b exp=1", busy); end
        n_checks++; if (wr_addr.size() !== DEPTH || frame_bad() !== 0) begin n_fail++; $display("FAIL b2b_frame1 got=%0d writes/%0d bad exp=%0d/0", wr_addr.size(), frame_bad(), DEPTH); end
        clear_logs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout got=busy exp=idle"); end
        n_checks++; if (wr_addr.size() !== DEPTH || frame_bad() !== 0) begin n_fail++; $display("FAIL b2b_frame2 got=%0d writes/%0d bad exp=%0d/0", wr_addr.size(), frame_bad(), DEPTH); end
        exp_frames += 2;
        n_checks++; if (frame_cnt !== (STATS ? 16'(exp_frames) : 16'd0)) begin n_fail++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, STATS ? exp_frames : 0); end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        pulse_sof();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_rd && bus.o_wr) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL arst_find_burst got=none exp=burst"); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.o_rd !== 1'b0 || bus.o_wr !== 1'b0 || bus.o_pix_valid !== 1'b0) begin n_fail++; $display("FAIL arst_strobes rd/wr/pv got=%b/%b/%b exp=0/0/0", bus.o_rd, bus.o_wr, bus.o_pix_valid); end
        n_checks++; if (busy !== 1'b0 || bus.o_waddr !== '0 || bus.o_wdata !== '0) begin n_fail++; $display("FAIL arst_state busy/addr/data got=%b/%0d/%h exp=0/0/0", busy, bus.o_waddr, bus.o_wdata); end
        n_checks++; if (frame_cnt !== 16'd0 || resync_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_cnts got=%0d/%0d exp=0/0", frame_cnt, resync_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL arst_release busy/wr got=%b/%b exp=0/0", busy, bus.o_wr); end
    endtask

    initial begin
        test_reset();
        test_idle_no_sof();
        test_full_frame();
        test_almost_empty();
        test_resync();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
